result_bcd_converter: RTL and testbench
=======================================

Name: result_bcd_converter

Overview:
- Sequential binary-to-BCD stage directly downstream of the arithmetic stage (Operacion).
- Takes the 20-bit magnitude `resultado` and the sign `signo_resultado`, and produces six BCD digits, a sign flag, a leading-zero mask and an overflow flag for the display multiplexer.
- Uses iterative double-dabble: one shift per clock, with start/busy/done handshake.
- Replaces the combinational digit split.

Parameters:
- WIDTH, 20, input magnitude width; also the number of conversion cycles.
- MAXVAL, 999999, largest value representable in six digits; anything above saturates.

Ports:
- clk  input  1  system clock (50 MHz domain or clk1kHz; block is rate-agnostic)
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request conversion; sampled only in IDLE
- resultado  input  WIDTH  unsigned magnitude to convert
- signo_resultado  input  1  sign of result, 1 = negative
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when outputs are updated
- dres0..dres5  output  4 each  BCD digits; dres0 = units, dres5 = hundred-thousands
- signo_out  output  1  latched sign, forced 0 for a zero result
- lz_mask  output  6  bit i = 1 means digit i is a leading zero to blank; bit 0 is always 0
- overflow  output  1  latched; captured magnitude exceeded MAXVAL

Behaviour:
- Reset is asynchronous and active-low: one clock `clk`, reset `rst_n`. While rst_n = 0:
  - state = IDLE
  - busy = 0, done = 0, overflow = 0, signo_out = 0
  - dres0..dres5 = 0, lz_mask = 6'b111110
  - internal shift and BCD registers cleared, cycle counter = 0
- Reset mid-conversion aborts it. No done is produced, and outputs show the reset values.
- State machine:
  - IDLE: if start = 1 at edge E0, capture resultado into the shift register, clear the 24-bit BCD accumulator and the counter, latch signo_resultado and ovf_int = (resultado > MAXVAL), then go to CONV. busy = 1 from after E0.
  - CONV: each edge performs one double-dabble step: every BCD nibble ≥ 5 gets +3, then {bcd, shift} shifts left by 1 and the counter increments. After the WIDTH-th step (edge E20), go to LOAD.
  - LOAD (edge E21): update the outputs, assert done = 1 for exactly the following cycle, deassert busy, return to IDLE.
- Latency: start sampled at E0, outputs valid and done high after E21 (WIDTH + 1 edges). done falls after E22.
- Output load rules at LOAD:
  - If ovf_int = 1: all digits = 9, overflow = 1, lz_mask = 0.
  - Else: digits come from the BCD accumulator and overflow = 0.
  - lz_mask bit i (i = 1..5) = 1 iff digits i..5 are all zero.
  - signo_out = latched sign AND (value ≠ 0); no "-0" is ever shown.
- Outputs hold their last loaded values between conversions. Inputs may change freely after E0.
- start while busy (CONV or LOAD) is ignored. No queueing.
- start held high continuously: a new conversion begins on the first edge back in IDLE, i.e. the edge after LOAD. This gives back-to-back conversions every WIDTH + 2 cycles.
- Only the low 24 BCD bits (six nibbles) are kept. Values above MAXVAL never reach the digit registers unsaturated.

Test Plan:
- Reset, then start with resultado = 123456, sign = 0 → busy high for 21 cycles; done pulse 21 edges after start; dres5..dres0 = 1,2,3,4,5,6; lz_mask = 000000; overflow = 0; signo_out = 0.
- resultado = 42, sign = 1 → digits 0,0,0,0,4,2; lz_mask = 111100; signo_out = 1. Then resultado = 0, sign = 1 → all digits 0; lz_mask = 111110; signo_out = 0.
- resultado = 999999 → all digits 9, overflow = 0. Then resultado = 1000000 and then 1048575 → all digits 9, overflow = 1, lz_mask = 000000.
- Pulse start with 7 during a conversion of 555 (5 cycles after the first start) → only one done pulse; result 555; the second request is ignored.
- Assert rst_n = 0 asynchronously at cycle 10 of a conversion of 314159 → outputs are immediately at reset values, no done pulse. After release, a fresh start with 314159 completes correctly.
- start held high with resultado = 1, 2, 3 changed each done → done pulses every 22 cycles, with outputs 1, 2, 3 in order.

Source files
------------

// File: rtl/result_bcd_converter.sv
// result_bcd_converter: iterative double-dabble converter from a signed 20-bit result to six BCD display digits
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   request a conversion (sampled only while idle)
//   resultado               unsigned magnitude to convert
//   signo_resultado         sign of the magnitude, 1 = negative
//   busy                    high while a conversion is in progress
//   done                    one-cycle pulse when the outputs have been updated
//   dres0..dres5            BCD digits, dres0 = units, dres5 = hundred-thousands
//   signo_out               latched sign, never set for a zero result
//   lz_mask                 bit i set when digit i is a leading zero (bit 0 always clear)
//   overflow                latched, magnitude exceeded MAXVAL and digits are saturated to 9
module result_bcd_converter #(
   parameter int WIDTH  = 20,
   parameter int MAXVAL = 999999
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] resultado,
   input  logic             signo_resultado,
   output logic             busy,
   output logic             done,
   output logic [3:0]       dres0,
   output logic [3:0]       dres1,
   output logic [3:0]       dres2,
   output logic [3:0]       dres3,
   output logic [3:0]       dres4,
   output logic [3:0]       dres5,
   output logic             signo_out,
   output logic [5:0]       lz_mask,
   output logic             overflow
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] shift_q;
   logic [23:0] bcd_q, bcd_adj, load_bcd;
   logic [CW-1:0] cnt_q;
   logic sign_q, ovf_q;
   logic [5:0] lz_nx;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = IDLE;
      state_nx = state == IDLE ? (start ? CONV : IDLE) :
                 state == CONV ? (cnt_q == CW'(WIDTH - 1) ? LOAD : CONV) : IDLE;
   end
   assign busy = state != IDLE;
   // add-3 correction applied to every nibble before each shift
   for (genvar i = 0; i < 6; i++) begin : g_adj
      assign bcd_adj[4*i+:4] = bcd_q[4*i+:4] >= 4'd5 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
   end
   assign load_bcd = ovf_q ? 24'h999999 : bcd_q;
   // a digit is blanked when it and every more significant digit are zero
   assign lz_nx[0] = 1'b0;
   for (genvar i = 1; i < 6; i++) begin : g_lz
      assign lz_nx[i] = ~|load_bcd[23:4*i];
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         shift_q   <= '0;
         bcd_q     <= '0;
         cnt_q     <= '0;
         sign_q    <= 1'b0;
         ovf_q     <= 1'b0;
         done      <= 1'b0;
         dres0     <= '0;
         dres1     <= '0;
         dres2     <= '0;
         dres3     <= '0;
         dres4     <= '0;
         dres5     <= '0;
         signo_out <= 1'b0;
         lz_mask   <= 6'b111110;
         overflow  <= 1'b0;
      end else begin
         done <= state == LOAD;
         if (state == IDLE && start) begin
            shift_q <= resultado;
            bcd_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= signo_resultado;
            ovf_q   <= 32'(resultado) > 32'(MAXVAL);
         end else if (state == CONV) begin
            {bcd_q, shift_q} <= {bcd_adj[22:0], shift_q, 1'b0};
            cnt_q <= cnt_q + 1'b1;
         end else if (state == LOAD) begin
            dres0     <= load_bcd[3:0];
            dres1     <= load_bcd[7:4];
            dres2     <= load_bcd[11:8];
            dres3     <= load_bcd[15:12];
            dres4     <= load_bcd[19:16];
            dres5     <= load_bcd[23:20];
            overflow  <= ovf_q;
            lz_mask   <= lz_nx;
            signo_out <= sign_q & (|load_bcd);
         end
      end
endmodule

// File: tb/tb_result_bcd_converter.sv
// tb_result_bcd_converter: randomized self-checking bench for result_bcd_converter
module tb_result_bcd_converter;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, signo_resultado = 1'b0;
   logic [19:0] resultado = '0;
   logic busy, done, signo_out, overflow;
   logic [3:0] dres0, dres1, dres2, dres3, dres4, dres5;
   logic [5:0] lz_mask;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   result_bcd_converter dut (
      .clk(clk), .rst_n(rst_n), .start(start), .resultado(resultado),
      .signo_resultado(signo_resultado), .busy(busy), .done(done),
      .dres0(dres0), .dres1(dres1), .dres2(dres2), .dres3(dres3), .dres4(dres4), .dres5(dres5),
      .signo_out(signo_out), .lz_mask(lz_mask), .overflow(overflow)
   );

   localparam logic [33:0] RESET_VEC = {2'b00, 24'h000000, 6'b111110, 2'b00};

   function automatic logic [31:0] obs();
      return {dres5, dres4, dres3, dres2, dres1, dres0, lz_mask, overflow, signo_out};
   endfunction

   // decimal reference: saturate, split with division, derive blanking from the quotient
   function automatic logic [31:0] model(int unsigned v, bit s);
      int unsigned m = v > 999999 ? 999999 : v;
      int unsigned p = 1;
      logic [23:0] d;
      logic [5:0] lz;
      for (int i = 0; i < 6; i++) begin
         d[4*i+:4] = 4'((m / p) % 10);
         lz[i] = i != 0 && (m / p) == 0;
         p = p * 10;
      end
      return {d, lz, v > 999999, s && v != 0};
   endfunction

   task automatic apply_reset();
      rst_n = 1'b0;
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic start_conv(input int unsigned v, input bit s);
      @(negedge clk);
      start = 1'b1;
      resultado = 20'(v);
      signo_resultado = s;
      @(negedge clk);
      start = 1'b0;
   endtask

   // returns negedge samples until done, and how many of them showed busy
   task automatic wait_done(output int lat, output int nbusy);
      lat = 0;
      nbusy = 0;
      while (!done && lat < 100) begin
         if (busy) nbusy++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({busy, done, obs()} !== RESET_VEC) begin
         errors++;
         $display("FAIL reset_state: got %h expected %h", {busy, done, obs()}, RESET_VEC);
      end
   endtask

   task automatic test_basic();
      int lat, nb;
      start_conv(123456, 0);
      wait_done(lat, nb);
      checks++;
      if (lat !== 21) begin
         errors++;
         $display("FAIL basic_latency: got %0d expected 21", lat);
      end
      checks++;
      if (nb !== 21) begin
         errors++;
         $display("FAIL basic_busy_cycles: got %0d expected 21", nb);
      end
      checks++;
      if (obs() !== model(123456, 0)) begin
         errors++;
         $display("FAIL basic_value: got %h expected %h", obs(), model(123456, 0));
      end
      @(negedge clk);
      checks++;
      if ({done, busy} !== 2'b00) begin
         errors++;
         $display("FAIL basic_done_pulse: done/busy got %b expected 00", {done, busy});
      end
   endtask

   task automatic test_signs();
      int lat, nb;
      int unsigned vals[2] = '{42, 0};
      foreach (vals[k]) begin
         start_conv(vals[k], 1);
         wait_done(lat, nb);
         checks++;
         if (lat !== 21 || obs() !== model(vals[k], 1)) begin
            errors++;
            $display("FAIL sign_%0d: got %h lat %0d expected %h lat 21", vals[k], obs(), lat, model(vals[k], 1));
         end
      end
   endtask

   task automatic test_saturation();
      int lat, nb;
      int unsigned vals[3] = '{999999, 1000000, 1048575};
      foreach (vals[k]) begin
         start_conv(vals[k], k == 2);
         wait_done(lat, nb);
         checks++;
         if (lat !== 21 || obs() !== model(vals[k], k == 2)) begin
            errors++;
            $display("FAIL saturate_%0d: got %h lat %0d expected %h lat 21", vals[k], obs(), lat, model(vals[k], k == 2));
         end
      end
   endtask

   task automatic test_random();
      int lat, nb;
      int unsigned v;
      bit s;
      for (int k = 0; k < 24; k++) begin
         v = (k % 3 == 0) ? $urandom_range(0, 999) : $urandom_range(0, 1048575);
         s = 1'($urandom);
         start_conv(v, s);
         wait_done(lat, nb);
         checks++;
         if (lat !== 21 || obs() !== model(v, s)) begin
            errors++;
            $display("FAIL random_%0d: got %h lat %0d expected %h lat 21", v, obs(), lat, model(v, s));
         end
      end
   endtask

   task automatic test_start_ignored();
      int ndone = 0;
      logic [31:0] seen = '0;
      start_conv(555, 0);
      repeat (4) @(negedge clk);
      start = 1'b1;
      resultado = 20'd7;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (done) begin
            ndone++;
            seen = obs();
         end
         @(negedge clk);
      end
      checks++;
      if (ndone !== 1) begin
         errors++;
         $display("FAIL ignore_done_count: got %0d expected 1", ndone);
      end
      checks++;
      if (seen !== model(555, 0)) begin
         errors++;
         $display("FAIL ignore_value: got %h expected %h", seen, model(555, 0));
      end
   endtask

   task automatic test_async_reset();
      int ndone = 0, lat, nb;
      start_conv(314159, 0);
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, obs()} !== RESET_VEC) begin
         errors++;
         $display("FAIL async_reset_immediate: got %h expected %h", {busy, done, obs()}, RESET_VEC);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 30; k++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      checks++;
      if (ndone !== 0 || {busy, done, obs()} !== RESET_VEC) begin
         errors++;
         $display("FAIL async_reset_abort: done pulses %0d state %h expected 0 and %h", ndone, {busy, done, obs()}, RESET_VEC);
      end
      start_conv(314159, 0);
      wait_done(lat, nb);
      checks++;
      if (lat !== 21 || obs() !== model(314159, 0)) begin
         errors++;
         $display("FAIL async_reset_restart: got %h lat %0d expected %h lat 21", obs(), lat, model(314159, 0));
      end
   endtask

   task automatic test_back_to_back();
      int gap, lat, nb;
      @(negedge clk);
      start = 1'b1;
      resultado = 20'd1;
      signo_resultado = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         wait_done(lat, nb);
         gap = lat + 1;
         checks++;
         if (obs() !== model(k, 0) || (k > 1 && gap !== 22)) begin
            errors++;
            $display("FAIL back_to_back_%0d: got %h gap %0d expected %h gap 22", k, obs(), gap, model(k, 0));
         end
         resultado = 20'(k + 1);
         if (k == 3) start = 1'b0;
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signs();
      test_saturation();
      test_random();
      test_start_ignored();
      test_async_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
